bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_controller.sv | 100 ++++++++++
 tb/tb_bist_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// BIST sequencer for a 6:3 counter: seeds a 3-bit MISR, compacts N_PATTERNS
// responses, compares against a golden signature and reports pass/fail.
module bist_controller #(
  parameter int         N_PATTERNS = 63,
  parameter logic [2:0] GOLDEN_SIG = 3'b000,
  parameter logic [2:0] MISR_SEED  = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] cut_sum,
  output logic       lfsr_rst,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CMP,
    S_DONE
  } state_e;

  localparam logic [6:0] LAST = 7'(N_PATTERNS);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] cnt_inc;
  logic [2:0] sig_q, sig_d;
  logic [2:0] misr_nxt;
  logic       pass_q, pass_d;

  // x^3+x+1 shift with the response folded in
  assign misr_nxt = {sig_q[1], sig_q[0] ^ sig_q[2], sig_q[2]} ^ cut_sum;
  assign cnt_inc  = cnt_q + 7'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sig_d   = MISR_SEED;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sig_d = misr_nxt;
          cnt_d = cnt_inc;
          if (cnt_inc == LAST) state_d = S_CMP;
        end
      end
      S_CMP: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        pass_d = pass_q;
        if (start) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sig_q   <= MISR_SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == S_INIT) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign lfsr_rst  = (state_q != S_RUN);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed and randomized checks of bist_controller against a
// polynomial-arithmetic MISR model and cycle-count expectations.
module tb_bist_controller;

  localparam int NA = 4;
  localparam int NB = 63;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [2:0] cut;
  logic       start_b, abort_b;
  logic [2:0] cut_b;

  logic       a_lfsr, a_busy, a_done, a_pass;
  logic [2:0] a_sig;
  logic       c_lfsr, c_busy, c_done, c_pass;
  logic [2:0] c_sig;
  logic       b_lfsr, b_busy, b_done, b_pass;
  logic [2:0] b_sig;

  int checks = 0;
  int errors = 0;

  logic [2:0] va [NA];

  always #5 clk = ~clk;

  bist_controller #(
    .N_PATTERNS(NA), .GOLDEN_SIG(3'b011), .MISR_SEED(3'b000)
  ) u_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cut_sum(cut), .lfsr_rst(a_lfsr), .busy(a_busy),
    .done(a_done), .pass(a_pass), .signature(a_sig)
  );

  bist_controller #(
    .N_PATTERNS(NA), .GOLDEN_SIG(3'b000), .MISR_SEED(3'b000)
  ) u_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cut_sum(cut), .lfsr_rst(c_lfsr), .busy(c_busy),
    .done(c_done), .pass(c_pass), .signature(c_sig)
  );

  bist_controller #(
    .N_PATTERNS(NB), .GOLDEN_SIG(3'b000), .MISR_SEED(3'b000)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .cut_sum(cut_b), .lfsr_rst(b_lfsr), .busy(b_busy),
    .done(b_done), .pass(b_pass), .signature(b_sig)
  );

  // signature as polynomial: s*x mod (x^3+x+1), plus response
  function automatic logic [2:0] misr(input logic [2:0] s,
                                      input logic [2:0] r);
    logic [3:0] t;
    t = {s, 1'b0};
    if (t[3]) t = t ^ 4'b1011;
    return t[2:0] ^ r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_pass", a_pass, 0);
    chk("rst_a_lfsr", a_lfsr, 1);
    chk("rst_a_sig", a_sig, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_done", b_done, 0);
    chk("rst_b_lfsr", b_lfsr, 1);
    chk("rst_b_sig", b_sig, 0);
  endtask

  task automatic run_a();
    logic [2:0] s;
    s = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_init_busy", a_busy, 1);
    chk("a_init_lfsr", a_lfsr, 1);
    tick();
    for (int k = 0; k < NA; k++) begin
      cut = va[k];
      chk("a_run_lfsr", a_lfsr, 0);
      chk("a_run_busy", a_busy, 1);
      tick();
      s = misr(s, va[k]);
      chk("a_run_sig", a_sig, s);
    end
    cut = 3'b000;
    abort = 1'b1;
    chk("a_cmp_lfsr", a_lfsr, 1);
    chk("a_cmp_busy", a_busy, 0);
    chk("a_cmp_done", a_done, 0);
    tick();
    chk("a_done", a_done, 1);
    chk("a_pass", a_pass, s == 3'b011);
    chk("a_sig", a_sig, s);
    chk("c_done", c_done, 1);
    chk("c_pass", c_pass, s == 3'b000);
    chk("c_sig", c_sig, s);
    tick();
    abort = 1'b0;
    chk("a_done_hold", a_done, 1);
    chk("a_sig_hold", a_sig, s);
    chk("a_pass_hold", a_pass, s == 3'b011);
  endtask

  task automatic run_b_rand();
    logic [2:0] s;
    s = 3'b000;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    for (int k = 0; k < NB; k++) begin
      cut_b = 3'($urandom);
      tick();
      s = misr(s, cut_b);
    end
    cut_b = 3'b000;
    chk("b_cmp_lfsr", b_lfsr, 1);
    chk("b_cmp_sig", b_sig, s);
    tick();
    chk("b_rand_done", b_done, 1);
    chk("b_rand_sig", b_sig, s);
    chk("b_rand_pass", b_pass, s == 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s;
    int n_busy, n_low, cyc;

    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    cut     = 3'b000;
    start_b = 1'b0;
    abort_b = 1'b0;
    cut_b   = 3'b000;
    #3;
    chk_reset_vals();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("idle_a_busy", a_busy, 0);
    chk("idle_a_done", a_done, 0);

    va[0] = 3'b001;
    va[1] = 3'b000;
    va[2] = 3'b000;
    va[3] = 3'b000;
    run_a();
    chk("dir_a_sig", a_sig, 3'b011);
    chk("dir_a_pass", a_pass, 1);
    chk("dir_c_pass", c_pass, 0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NA; k++) va[k] = 3'($urandom);
      run_a();
    end

    s = 3'b000;
    for (int k = 0; k < NA; k++) s = misr(s, 3'b101);
    cut = 3'b101;
    start = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 1; j <= 7; j++) begin
        tick();
        chk("b2b_done", a_done, j == 7);
        if (j == 1) chk("b2b_init_busy", a_busy, 1);
      end
      chk("b2b_sig", a_sig, s);
      chk("b2b_pass", a_pass, s == 3'b011);
    end
    start = 1'b0;
    cut = 3'b000;

    #2 reset = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    reset = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    cut = 3'b111;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    reset = 1'b0;
    cut = 3'b000;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("post_rst_done", a_done, 0);
      chk("post_rst_busy", a_busy, 0);
    end

    s = 3'b000;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      cut_b = 3'($urandom);
      tick();
      s = misr(s, cut_b);
    end
    cut_b = 3'($urandom);
    abort_b = 1'b1;
    tick();
    chk("abort_busy", b_busy, 0);
    chk("abort_done", b_done, 0);
    chk("abort_pass", b_pass, 0);
    chk("abort_lfsr", b_lfsr, 1);
    chk("abort_sig", b_sig, s);
    start_b = 1'b1;
    tick();
    chk("abort_idle_ign", b_busy, 1);
    start_b = 1'b0;
    tick();
    chk("abort_init_busy", b_busy, 0);
    chk("abort_init_sig", b_sig, s);
    abort_b = 1'b0;

    run_b_rand();
    run_b_rand();

    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cut_b = 3'b000;
    n_busy = 0;
    n_low = 0;
    cyc = 0;
    while (!b_done && cyc < 200) begin
      if (b_busy) n_busy++;
      if (!b_lfsr) n_low++;
      tick();
      cyc++;
    end
    chk("zero_done", b_done, 1);
    chk("zero_cycles", cyc, NB + 2);
    chk("zero_busy_cnt", n_busy, NB + 1);
    chk("zero_low_cnt", n_low, NB);
    chk("zero_sig", b_sig, 0);
    chk("zero_pass", b_pass, 1);

    #2 reset = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
